lsu: RTL

Load/store unit for the RiscyD2 core, on the memory side of the ALU's `address` output. It accepts a load or store request during the core's memory stage and runs a single-beat word-aligned bus transaction with a ready handshake. It handles byte-lane steering and store strobes, extends load data by sign or zero, and reports misalignment, illegal-width and bus-timeout faults. Execution resumes when it pulses `done`.

---
 rtl/lsu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one word-aligned bus beat per request, with lane steering,
// load extension and misaligned / illegal-width / bus-timeout fault reporting.
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] rs2_val,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_ILL  = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] load_q, load_d;

  function automatic logic width_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cause_d = CAUSE_NONE;
          if (!is_load && !is_store) begin
            state_d = FINISH;
          end else if (!width_legal(is_store, funct3)) begin
            state_d = FINISH;
            cause_d = CAUSE_ILL;
          end else if (misaligned(funct3, address[1:0])) begin
            state_d = FINISH;
            cause_d = CAUSE_MIS;
          end else begin
            // Bus registers load only for requests that really reach the bus.
            state_d = ACCESS;
            cnt_d   = '0;
            we_d    = is_store;
            addr_d  = {address[31:2], 2'b00};
            wdata_d = store_wdata(funct3, rs2_val);
            wstrb_d = is_store ? store_wstrb(funct3, address[1:0]) : 4'b0000;
            f3_d    = funct3;
            lane_d  = address[1:0];
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = FINISH;
          cause_d = CAUSE_NONE;
          if (!we_q) load_d = load_extract(f3_q, lane_q, mem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d = FINISH;
          cause_d = CAUSE_TMO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (state_q == ACCESS);
    busy        = (state_q == ACCESS);
    done        = (state_q == FINISH);
    fault       = done && (cause_q != CAUSE_NONE);
    fault_cause = done ? cause_q : CAUSE_NONE;
    mem_we      = we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    mem_wstrb   = wstrb_q;
    load_data   = load_q;
  end

endmodule
